// File: rtl/ctr_keystream_reader_pkg.sv
// Shared constants, types and helpers for the CTR keystream reader.
// Sizes the batch buffer and selects the per-mode block targets.
package ctr_keystream_reader_pkg;

  localparam int unsigned BATCH_BYTES       = 64;
  localparam int unsigned BLOCK_BYTES       = 16;
  localparam int unsigned WORD_WIDTH        = 32;
  localparam int unsigned BATCH_WIDTH       = BATCH_BYTES * 8;
  localparam int unsigned BATCH_WORDS       = BATCH_WIDTH / WORD_WIDTH;
  localparam int unsigned BLOCKS_PER_BATCH  = BATCH_BYTES / BLOCK_BYTES;
  localparam int unsigned XOF_TARGET_BLOCKS = 44;
  localparam int unsigned PRF_TARGET_BLOCKS = 8;
  localparam int unsigned WORD_IDX_W        = 4;
  localparam int unsigned BATCH_CNT_W       = 4;

  localparam logic XOF_MODE = 1'b0;
  localparam logic PRF_MODE = 1'b1;

  // Packed so that element BATCH_WORDS-1 is the most significant word of the batch.
  typedef logic [BATCH_WORDS-1:0][WORD_WIDTH-1:0] batch_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Batches needed to cover the mode's block target, rounded up.
  function automatic logic [BATCH_CNT_W-1:0] total_batches(input logic mode);
    int unsigned target;
    target = (mode == PRF_MODE) ? PRF_TARGET_BLOCKS : XOF_TARGET_BLOCKS;
    return BATCH_CNT_W'((target + BLOCKS_PER_BATCH - 1) / BLOCKS_PER_BATCH);
  endfunction

endpackage

// File: rtl/ctr_keystream_reader_ks_batch_fifo.sv
// Two-entry batch FIFO with a word-granular read port on the head slot.
// The output word is registered and already reflects the state after this cycle's write/pop.
module ks_batch_fifo
  import ctr_keystream_reader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_write,
  input  logic [BATCH_WIDTH-1:0] i_wdata,
  input  logic                   i_pop_word,
  output logic [WORD_WIDTH-1:0]  o_word,
  output logic                   o_empty,
  output logic                   o_last_word,
  output logic [1:0]             o_free_cnt
);

  batch_t                  r_slot [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;
  logic [WORD_IDX_W-1:0]   r_idx;
  logic [WORD_WIDTH-1:0]   r_word;

  batch_t                  w_slot_d [2];
  batch_t                  w_head_d;
  logic                    w_wr_ptr_d;
  logic                    w_rd_ptr_d;
  logic                    w_free_head;
  logic [1:0]              w_count_d;
  logic [WORD_IDX_W-1:0]   w_idx_d;
  logic [WORD_WIDTH-1:0]   w_word_d;

  always_comb begin
    w_slot_d    = r_slot;
    w_wr_ptr_d  = r_wr_ptr;
    w_rd_ptr_d  = r_rd_ptr;
    w_count_d   = r_count;
    w_idx_d     = r_idx;
    w_free_head = i_pop_word && (r_idx == WORD_IDX_W'(BATCH_WORDS - 1));
    if (i_clear) begin
      w_wr_ptr_d = 1'b0;
      w_rd_ptr_d = 1'b0;
      w_count_d  = 2'd0;
      w_idx_d    = '0;
    end else begin
      if (i_write) begin
        w_slot_d[r_wr_ptr] = batch_t'(i_wdata);
        w_wr_ptr_d         = ~r_wr_ptr;
      end
      if (i_pop_word) begin
        w_idx_d = r_idx + 1'b1;
      end
      if (w_free_head) begin
        w_rd_ptr_d = ~r_rd_ptr;
      end
      // A write and a head release in the same cycle cancel out in the occupancy.
      w_count_d = r_count + {1'b0, i_write} - {1'b0, w_free_head};
    end
    w_head_d = w_slot_d[w_rd_ptr_d];
    // Word k of a batch is element BATCH_WORDS-1-k, i.e. the bitwise inverse of the index.
    w_word_d = (w_count_d == 2'd0) ? '0 : w_head_d[~w_idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot   <= '{default: '0};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_idx    <= '0;
      r_word   <= '0;
    end else begin
      r_slot   <= w_slot_d;
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
      r_idx    <= w_idx_d;
      r_word   <= w_word_d;
    end
  end

  assign o_word      = r_word;
  assign o_empty     = (r_count == 2'd0);
  assign o_last_word = (r_idx == WORD_IDX_W'(BATCH_WORDS - 1));
  assign o_free_cnt  = 2'd2 - r_count;

endmodule

// File: rtl/ctr_keystream_reader.sv
// Consumer of the AES-256-CTR keystream generator: fetches 512-bit batches with one-ahead
// prefetch and streams them as 32-bit words until the mode's block target is delivered.
module ctr_keystream_reader
  import ctr_keystream_reader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_mode,
  output logic                   o_batch_req,
  input  logic                   i_batch_valid,
  input  logic [BATCH_WIDTH-1:0] i_batch_in,
  output logic [WORD_WIDTH-1:0]  o_word_out,
  output logic                   o_word_valid,
  input  logic                   i_word_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  state_e                 r_state;
  state_e                 w_state_d;
  logic                   r_mode;
  logic [BATCH_CNT_W-1:0] r_req_cnt;
  logic [BATCH_CNT_W-1:0] r_done_cnt;
  logic                   r_outstanding;

  logic [BATCH_CNT_W-1:0] w_total;
  logic                   w_run;
  logic                   w_start_ok;
  logic                   w_req;
  logic                   w_capture;
  logic                   w_accept;
  logic                   w_batch_done;
  logic                   w_run_last;
  logic                   w_fifo_empty;
  logic                   w_last_word;
  logic [1:0]             w_free_cnt;

  assign w_total      = total_batches(r_mode);
  assign w_run        = (r_state == StRun);
  assign w_start_ok   = i_start && !w_run;
  assign w_req        = w_run && !r_outstanding && (w_free_cnt != 2'd0) && (r_req_cnt < w_total);
  // Generator pulses without a matching request are dropped.
  assign w_capture    = w_run && i_batch_valid && r_outstanding;
  assign w_accept     = o_word_valid && i_word_ready;
  assign w_batch_done = w_accept && w_last_word;
  assign w_run_last   = w_batch_done && (r_done_cnt == w_total - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (w_start_ok) w_state_d = StRun;
      end
      StRun: begin
        if (w_run_last) w_state_d = StDone;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy       = w_run;
    o_done       = (r_state == StDone);
    o_batch_req  = w_req;
    o_word_valid = w_run && !w_fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= XOF_MODE;
      r_req_cnt     <= '0;
      r_done_cnt    <= '0;
      r_outstanding <= 1'b0;
    end else if (w_start_ok) begin
      r_mode        <= i_mode;
      r_req_cnt     <= '0;
      r_done_cnt    <= '0;
      r_outstanding <= 1'b0;
    end else if (w_run) begin
      if (w_req) begin
        r_req_cnt     <= r_req_cnt + 1'b1;
        r_outstanding <= 1'b1;
      end else if (w_capture) begin
        r_outstanding <= 1'b0;
      end
      if (w_batch_done) begin
        r_done_cnt <= r_done_cnt + 1'b1;
      end
    end
  end

  ks_batch_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start_ok),
    .i_write     (w_capture),
    .i_wdata     (i_batch_in),
    .i_pop_word  (w_accept),
    .o_word      (o_word_out),
    .o_empty     (w_fifo_empty),
    .o_last_word (w_last_word),
    .o_free_cnt  (w_free_cnt)
  );

endmodule

// File: tb/tb_ctr_keystream_reader.sv
// Scoreboard bench for ctr_keystream_reader: a model generator answers requests with patterned
// batches and queues the expected words; accepted words are queued and compared per scenario.
module tb_ctr_keystream_reader;
  import ctr_keystream_reader_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start;
  logic         i_mode;
  logic         o_batch_req;
  logic         i_batch_valid;
  logic [511:0] i_batch_in;
  logic [31:0]  o_word_out;
  logic         o_word_valid;
  logic         i_word_ready;
  logic         o_busy;
  logic         o_done;

  always #5 clk = ~clk;

  ctr_keystream_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_mode        (i_mode),
    .o_batch_req   (o_batch_req),
    .i_batch_valid (i_batch_valid),
    .i_batch_in    (i_batch_in),
    .o_word_out    (o_word_out),
    .o_word_valid  (o_word_valid),
    .i_word_ready  (i_word_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          req_pulses, drv_batches, gaps, viol, max_occ, sim_hit;
  int          gen_delay, gen_cnt;
  bit          gen_pending, gen_valid, watch_gaps;
  logic [7:0]  run_id = 8'h00;

  function automatic logic [31:0] pat(logic [7:0] run, int b, int k);
    return {8'hA0 + 8'(b * 16), run, 8'(b), 8'(k)};
  endfunction

  // One clock: observe before the edge, drive the generator model after it.
  task automatic tick();
    int captured, occ;
    @(negedge clk);
    captured = drv_batches - (gen_valid ? 1 : 0);
    occ = captured - got_q.size() / 16;
    if (occ > max_occ) max_occ = occ;
    if (o_batch_req) begin
      if (occ >= 2 || req_pulses > captured) viol++;
      req_pulses++;
      gen_pending = 1'b1;
      gen_cnt = gen_delay;
    end
    if (watch_gaps && o_busy && got_q.size() > 0 && !o_word_valid) gaps++;
    if (o_word_valid && i_word_ready) begin
      if (gen_valid && (got_q.size() % 16 == 15)) sim_hit++;
      got_q.push_back(o_word_out);
    end
    @(posedge clk);
    #1;
    i_start = 1'b0;
    i_batch_valid = 1'b0;
    gen_valid = 1'b0;
    if (gen_pending) begin
      if (gen_cnt <= 1) begin
        for (int k = 0; k < 16; k++) begin
          i_batch_in[511 - 32 * k -: 32] = pat(run_id, drv_batches, k);
          exp_q.push_back(pat(run_id, drv_batches, k));
        end
        i_batch_valid = 1'b1;
        gen_valid = 1'b1;
        drv_batches++;
        gen_pending = 1'b0;
      end else begin
        gen_cnt--;
      end
    end
  endtask

  task automatic clear_run();
    exp_q.delete();
    got_q.delete();
    req_pulses = 0; drv_batches = 0; gaps = 0; viol = 0; max_occ = 0; sim_hit = 0;
    gen_pending = 1'b0; gen_valid = 1'b0; gen_cnt = 0; watch_gaps = 1'b0;
    i_batch_valid = 1'b0;
  endtask

  task automatic do_start(logic mode);
    run_id = run_id + 8'h01;
    i_mode = mode;
    i_start = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_batch_valid = 1'b0;
    i_batch_in = '0; i_word_ready = 1'b0;
    clear_run();
    #3 rst_n = 1'b0;
    #3;
    checks++; if (o_batch_req !== 1'b0) begin errors++; $display("FAIL reset_batch_req: got %b expected 0", o_batch_req); end
    checks++; if (o_word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid: got %b expected 0", o_word_valid); end
    checks++; if (o_word_out !== 32'h0) begin errors++; $display("FAIL reset_word_out: got %h expected 0", o_word_out); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
    tick(); tick();
    rst_n = 1'b1;
    i_word_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (o_busy !== 1'b0 || o_batch_req !== 1'b0 || got_q.size() != 0) begin
      errors++; $display("FAIL idle_quiet: busy %b req %b words %0d expected 0 0 0", o_busy, o_batch_req, got_q.size());
    end
  endtask

  task automatic test_prf();
    bit early_done;
    early_done = 1'b0;
    clear_run(); gen_delay = 3; i_word_ready = 1'b1;
    do_start(PRF_MODE);
    for (int i = 0; i < 400 && got_q.size() < 32; i++) begin
      tick();
      if (got_q.size() < 32 && o_done) early_done = 1'b1;
    end
    checks++; if (got_q.size() != 32) begin errors++; $display("FAIL prf_word_count: got %0d expected 32", got_q.size()); end
    checks++; if (o_done !== 1'b1 || early_done) begin errors++; $display("FAIL prf_done_timing: done %b early %b expected 1 0", o_done, early_done); end
    checks++; if (req_pulses != 2) begin errors++; $display("FAIL prf_req_pulses: got %0d expected 2", req_pulses); end
    if (got_q.size() >= 17) begin
      checks++; if (got_q[0] !== {8'hA0, run_id, 8'h00, 8'h00}) begin errors++; $display("FAIL prf_word0: got %h expected %h", got_q[0], {8'hA0, run_id, 8'h00, 8'h00}); end
      checks++; if (got_q[16] !== {8'hB0, run_id, 8'h01, 8'h00}) begin errors++; $display("FAIL prf_word16: got %h expected %h", got_q[16], {8'hB0, run_id, 8'h01, 8'h00}); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL prf_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 0; i < 20; i++) tick();
    checks++; if (got_q.size() != 32 || req_pulses != 2 || o_done !== 1'b1 || o_word_valid !== 1'b0) begin
      errors++; $display("FAIL prf_after_done: words %0d reqs %0d done %b valid %b expected 32 2 1 0", got_q.size(), req_pulses, o_done, o_word_valid);
    end
  endtask

  task automatic test_xof();
    clear_run(); gen_delay = 3; i_word_ready = 1'b1; watch_gaps = 1'b1;
    do_start(XOF_MODE);
    for (int i = 0; i < 1500 && got_q.size() < 176; i++) tick();
    checks++; if (got_q.size() != 176) begin errors++; $display("FAIL xof_word_count: got %0d expected 176", got_q.size()); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL xof_no_bubble: got %0d gap cycles expected 0", gaps); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL xof_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    watch_gaps = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    checks++; if (req_pulses != 11) begin errors++; $display("FAIL xof_req_pulses: got %0d expected 11", req_pulses); end
    checks++; if (o_done !== 1'b1 || got_q.size() != 176) begin errors++; $display("FAIL xof_done: done %b words %0d expected 1 176", o_done, got_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int unstable;
    unstable = 0;
    clear_run(); gen_delay = 2; i_word_ready = 1'b1;
    do_start(XOF_MODE);
    for (int i = 0; i < 200 && got_q.size() < 5; i++) tick();
    i_word_ready = 1'b0;
    held = o_word_out;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_word_out !== held || o_word_valid !== 1'b1) unstable++;
    end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_word_stable: got %0d unstable cycles expected 0", unstable); end
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_no_accept: got %0d words expected 5", got_q.size()); end
    checks++; if (max_occ != 2) begin errors++; $display("FAIL bp_occupancy: got %0d expected 2", max_occ); end
    checks++; if (req_pulses != 2) begin errors++; $display("FAIL bp_req_during_stall: got %0d expected 2", req_pulses); end
    i_word_ready = 1'b1;
    for (int i = 0; i < 1500 && got_q.size() < 176; i++) tick();
    checks++; if (got_q.size() != 176) begin errors++; $display("FAIL bp_word_count: got %0d expected 176", got_q.size()); end
    checks++; if (viol != 0) begin errors++; $display("FAIL bp_req_rule: got %0d illegal requests expected 0", viol); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    tick(); tick();
  endtask

  task automatic test_simultaneous();
    clear_run(); gen_delay = 15; i_word_ready = 1'b1; watch_gaps = 1'b1;
    do_start(PRF_MODE);
    for (int i = 0; i < 400 && got_q.size() < 32; i++) tick();
    watch_gaps = 1'b0;
    checks++; if (sim_hit != 1) begin errors++; $display("FAIL sim_event_hit: got %0d expected 1", sim_hit); end
    checks++; if (max_occ != 1 || gaps != 0) begin errors++; $display("FAIL sim_occupancy: occ %0d gaps %0d expected 1 0", max_occ, gaps); end
    checks++; if (got_q.size() != 32) begin errors++; $display("FAIL sim_word_count: got %0d expected 32", got_q.size()); end
    if (got_q.size() >= 17) begin
      checks++; if (got_q[16] !== {8'hB0, run_id, 8'h01, 8'h00}) begin errors++; $display("FAIL sim_word16: got %h expected %h", got_q[16], {8'hB0, run_id, 8'h01, 8'h00}); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sim_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    tick(); tick();
  endtask

  task automatic test_spurious();
    bit spur_done, idle_bad;
    spur_done = 1'b0; idle_bad = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    clear_run(); i_word_ready = 1'b1;
    i_batch_in = {16{32'hDEAD_BEEF}};
    i_batch_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_word_valid || o_busy) idle_bad = 1'b1;
    end
    checks++; if (idle_bad || got_q.size() != 0) begin errors++; $display("FAIL spur_idle: bad %b words %0d expected 0 0", idle_bad, got_q.size()); end
    gen_delay = 3;
    do_start(PRF_MODE);
    for (int i = 0; i < 400 && got_q.size() < 32; i++) begin
      tick();
      if (got_q.size() == 8) begin
        i_mode = XOF_MODE;
        i_start = 1'b1;
      end
      if (!spur_done && drv_batches == 2 && !gen_valid && !gen_pending && got_q.size() >= 18) begin
        i_batch_in = {16{32'hDEAD_BEEF}};
        i_batch_valid = 1'b1;
        spur_done = 1'b1;
      end
    end
    for (int i = 0; i < 30; i++) tick();
    checks++; if (got_q.size() != 32) begin errors++; $display("FAIL spur_word_count: got %0d expected 32", got_q.size()); end
    checks++; if (req_pulses != 2) begin errors++; $display("FAIL spur_start_ignored: got %0d requests expected 2", req_pulses); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL spur_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midrun();
    clear_run(); gen_delay = 3; i_word_ready = 1'b1;
    do_start(XOF_MODE);
    for (int i = 0; i < 200 && got_q.size() < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({o_batch_req, o_word_valid, o_busy, o_done} !== 4'b0000) begin
      errors++; $display("FAIL midrun_reset_flags: got %b expected 0000", {o_batch_req, o_word_valid, o_busy, o_done});
    end
    checks++; if (o_word_out !== 32'h0) begin errors++; $display("FAIL midrun_reset_word: got %h expected 0", o_word_out); end
    tick(); tick();
    rst_n = 1'b1;
    clear_run();
    tick();
    do_start(PRF_MODE);
    for (int i = 0; i < 400 && got_q.size() < 32; i++) tick();
    checks++; if (got_q.size() != 32 || req_pulses != 2) begin
      errors++; $display("FAIL midrun_restart: words %0d reqs %0d expected 32 2", got_q.size(), req_pulses);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrun_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_prf();
    test_xof();
    test_backpressure();
    test_simultaneous();
    test_spurious();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete within 1 ms");
    $fatal(1, "timeout");
  end

endmodule
